// File: rtl/buzzer_sequencer.sv
// Round-robin scheduler for one shared buzzer: 4-note patterns + gap; `BUZZER_PREEMPT_EN lets req[0] abort other patterns.
// Grant 1 edge after pending with IDLE; no backpressure: requests merge into pending bits until served.
module buzzer_sequencer #(
    parameter int NOTE_TICKS = 7000000,
    parameter int GAP_TICKS  = 1000000,
    parameter int HP_SHIFT   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic       start,
    output logic       done,
    output logic       busy,
    output logic [1:0] cur_id,
    output logic [3:0] pending,
    output logic       buzzer
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam int DW = (NOTE_TICKS > 2) ? $clog2(NOTE_TICKS) : 1;
    localparam int GW = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;
    localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_TICKS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);

    function automatic logic [17:0] hp_entry(input logic [1:0] id, input logic [1:0] note);
        logic [17:0] e;
        case ({id, note})
            4'h0: e = 18'd50000;
            4'h1: e = 18'd25000;
            4'h2: e = 18'd16667;
            4'h3: e = 18'd12500;
            4'h4: e = 18'd191571;
            4'h5: e = 18'd151976;
            4'h6: e = 18'd127551;
            4'h7: e = 18'd90253;
            4'h8: e = 18'd50000;
            4'h9: e = 18'd0;
            4'hA: e = 18'd50000;
            4'hB: e = 18'd0;
            4'hC: e = 18'd12500;
            4'hD: e = 18'd16667;
            4'hE: e = 18'd25000;
            default: e = 18'd50000;
        endcase
        return e;
    endfunction

    // A nonzero entry never scales down to a rest.
    function automatic logic [17:0] eff_hp(input logic [17:0] e);
        logic [17:0] h;
        h = e >> HP_SHIFT;
        if (e != 18'd0 && h == 18'd0) h = 18'd1;
        return h;
    endfunction

    state_t          state, state_n;
    logic [1:0]      rr_ptr, rr_n;
    logic [1:0]      cur_id_n;
    logic [1:0]      note_idx, note_n;
    logic [17:0]     freq_cnt, freq_n;
    logic [DW-1:0]   dur_cnt, dur_n;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic            buzzer_n, start_n, done_n;
    logic [3:0]      pending_n;
    logic            preempt_pend, preempt_n;
    logic [17:0]     hp;
    logic [1:0]      winner, cand;
    logic            found;

    always_comb begin
        state_n   = state;
        rr_n      = rr_ptr;
        cur_id_n  = cur_id;
        note_n    = note_idx;
        freq_n    = freq_cnt;
        dur_n     = dur_cnt;
        gap_n     = gap_cnt;
        buzzer_n  = buzzer;
        start_n   = 1'b0;
        done_n    = 1'b0;
        pending_n = pending | req;
        preempt_n = preempt_pend;
        hp        = eff_hp(hp_entry(cur_id, note_idx));
        found     = 1'b0;
        winner    = 2'd0;
        cand      = 2'd0;

        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        if (preempt_pend) winner = 2'd0;

        case (state)
            IDLE: begin
                buzzer_n = 1'b0;
                if (pending != 4'd0) begin
                    state_n   = PLAY;
                    cur_id_n  = winner;
                    rr_n      = winner;
                    note_n    = 2'd0;
                    freq_n    = 18'd0;
                    dur_n     = '0;
                    start_n   = 1'b1;
                    preempt_n = 1'b0;
                    // A request landing on the clearing edge keeps its bit set.
                    pending_n = (pending & ~(4'b0001 << winner)) | req;
                end
            end
            PLAY: begin
                if (hp == 18'd0) begin
                    freq_n   = 18'd0;
                    buzzer_n = 1'b0;
                end else if (freq_cnt == hp - 18'd1) begin
                    freq_n   = 18'd0;
                    buzzer_n = ~buzzer;
                end else begin
                    freq_n = freq_cnt + 18'd1;
                end
                if (dur_cnt == NOTE_LAST) begin
                    dur_n    = '0;
                    freq_n   = 18'd0;
                    buzzer_n = 1'b0;
                    if (note_idx == 2'd3) begin
                        done_n  = 1'b1;
                        state_n = GAP;
                        gap_n   = '0;
                    end else begin
                        note_n = note_idx + 2'd1;
                    end
                end else begin
                    dur_n = dur_cnt + DW'(1);
                end
            end
            GAP: begin
                buzzer_n = 1'b0;
                if (gap_cnt == GAP_LAST) begin
                    gap_n   = '0;
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_n  = IDLE;
                buzzer_n = 1'b0;
            end
        endcase

`ifdef BUZZER_PREEMPT_EN
        // Alarm pattern 0 cuts any other pattern short; it is then granted ahead of the RR order.
        if ((state == PLAY || state == GAP) && req[0] && cur_id != 2'd0) begin
            state_n   = IDLE;
            buzzer_n  = 1'b0;
            done_n    = 1'b0;
            note_n    = 2'd0;
            freq_n    = 18'd0;
            dur_n     = '0;
            gap_n     = '0;
            preempt_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= 2'd3;
            cur_id       <= 2'd0;
            note_idx     <= 2'd0;
            freq_cnt     <= 18'd0;
            dur_cnt      <= '0;
            gap_cnt      <= '0;
            buzzer       <= 1'b0;
            start        <= 1'b0;
            done         <= 1'b0;
            pending      <= 4'd0;
            preempt_pend <= 1'b0;
        end else begin
            state        <= state_n;
            rr_ptr       <= rr_n;
            cur_id       <= cur_id_n;
            note_idx     <= note_n;
            freq_cnt     <= freq_n;
            dur_cnt      <= dur_n;
            gap_cnt      <= gap_n;
            buzzer       <= buzzer_n;
            start        <= start_n;
            done         <= done_n;
            pending      <= pending_n;
            preempt_pend <= preempt_n;
        end
    end

    assign busy = (state == PLAY) || (state == GAP);

endmodule

// File: doc/buzzer_sequencer.md
# buzzer_sequencer

Shared-buzzer scheduler: accepts single-cycle pattern requests from four requesters (button handlers, alarm, status), holds them pending, and grants the one tone generator round-robin. Plays each granted pattern as four fixed notes of NOTE_TICKS cycles each, followed by a silent gap. Sits between the debounced event logic and the buzzer pin; drives the pin directly.

## Interface
- NOTE_TICKS, 7000000: note duration in clk cycles (70 ms at 100 MHz).
- GAP_TICKS, 1000000: silent gap after every pattern, in cycles.
- HP_SHIFT, 0: right-shift applied to every half-period table entry (simulation scaling).
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- req  in  4  req[i] single-cycle pulse requests pattern i.
- start  out  1  one-cycle pulse: granted pattern begins.
- done  out  1  one-cycle pulse: pattern finished all 4 notes.
- busy  out  1  high in PLAY and GAP.
- cur_id  out  2  id of pattern being played/last played.
- pending  out  4  latched unserved requests.
- buzzer  out  1  square-wave output to buzzer pin.

## Operation
- Half-period table (18-bit, cycles), notes 0..3:
  - P0: 50000, 25000, 16667, 12500. P1: 191571, 151976, 127551, 90253.
  - P2: 50000, 0, 50000, 0 (beep-rest alarm). P3: 12500, 16667, 25000, 50000.
- Effective half-period h = entry >> HP_SHIFT; if entry nonzero and h = 0, h = 1. Entry 0 = rest: buzzer held 0.
- pending[i] set on req[i]; duplicate req while pending merges (no count). Cleared when granted; a req[i] on the clearing edge wins (bit stays 1).
- Round-robin: search starts at last granted id + 1 mod 4; reset pointer so first search starts at 0.
- States: IDLE, PLAY, GAP.
  - IDLE: buzzer 0. If pending != 0: grant winner, cur_id <= winner, note idx <= 0, freq_cnt <= 0, dur_cnt <= 0, buzzer <= 0, start pulse, -> PLAY.
  - PLAY: freq_cnt counts 0..h-1; at h-1 wraps to 0 and toggles buzzer (rest: no toggle, buzzer 0). dur_cnt counts 0..NOTE_TICKS-1; at wrap, next note with freq_cnt <= 0, buzzer <= 0. At wrap of note 3: done pulse, buzzer <= 0, -> GAP.
  - GAP: buzzer 0, count GAP_TICKS cycles, -> IDLE.
- Requests arriving in PLAY/GAP only set pending; served after return to IDLE.

## Timing
- Reset values: start 0, done 0, busy 0, cur_id 0, pending 0, buzzer 0, state IDLE, RR pointer 3.
- req[i] high at edge E0 -> pending[i] = 1 after E0; if IDLE at E1, grant at E1: start/busy high after E1, pending[i] 0.
- First buzzer toggle h cycles after grant edge; tone period 2h cycles.
- PLAY = exactly 4*NOTE_TICKS cycles; done high in first GAP cycle; GAP = GAP_TICKS cycles; IDLE lasts 1 cycle min before next grant. Back-to-back pattern pitch = 4*NOTE_TICKS + GAP_TICKS + 1.
- Reset mid-pattern: all outputs to reset values immediately, pending requests lost.

## Configuration
- BUZZER_PREEMPT_EN defined: req[0] while PLAY/GAP of a pattern id != 0 aborts it on the next edge: buzzer 0, no done pulse, state IDLE with pending[0]=1, granted on the following edge (RR bypassed; id 0 fixed priority for preemption only). Same-id req[0] during P0 only pends.
- Undefined: no preemption; req[0] is an ordinary round-robin requester.

## Test plan
- NOTE_TICKS=40, GAP_TICKS=8, HP_SHIFT=12 for all.
- Single req[0] pulse -> start 1 cycle later; buzzer half-periods 12,6,4,3 cycles per note; done after 160 cycles; busy low after 168+.
- req = 4'b1111 same cycle -> grant order 0,1,2,3, pending 1111 -> 1110 -> 1100 -> 1000 -> 0000.
- req[2] -> notes 1 and 3 buzzer stays 0 for 40 cycles each; notes 0/2 half-period 12.
- req[1] pulsed 3 times during P1 play -> exactly one more P1 pattern.
- Reset asserted at cycle 50 of P0 -> buzzer, busy, pending 0 same cycle; no done.
- BUZZER_PREEMPT_EN: req[0] at cycle 60 of P3 -> buzzer 0 next edge, no done, start with cur_id=0 one edge later; without macro P3 completes first.
